// File: rtl/ryg_sequence_monitor.sv
// Passive checker for the two-lane R/Y/G lamp buses: locks to the 4-pattern
// light cycle, reports the cycle position and flags illegal or mistimed sequences.
module ryg_sequence_monitor #(
    parameter int unsigned GREEN_LEN  = 6,
    parameter int unsigned YELLOW_LEN = 2,
    parameter int unsigned PH_W       = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       R,
    input  logic [1:0]       Y,
    input  logic [1:0]       G,
    input  logic             clr_err,
    output logic             locked,
    output logic [PH_W-1:0]  phase,
    output logic             cycle_done,
    output logic             err_pulse,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned MAX_LEN = (GREEN_LEN > YELLOW_LEN) ? GREEN_LEN : YELLOW_LEN;
    localparam int unsigned D_W     = $clog2(MAX_LEN + 1);

    localparam logic [5:0] PAT_P0 = 6'b01_00_10;
    localparam logic [5:0] PAT_P1 = 6'b01_10_00;
    localparam logic [5:0] PAT_P2 = 6'b10_00_01;
    localparam logic [5:0] PAT_P3 = 6'b10_01_00;

    localparam logic [2:0] CODE_ILLEGAL = 3'd1;
    localparam logic [2:0] CODE_EARLY   = 3'd2;
    localparam logic [2:0] CODE_LATE    = 3'd3;
    localparam logic [2:0] CODE_ORDER   = 3'd4;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic {
        HUNT,
        TRACK
    } state_t;

    state_t           state;
    logic [1:0]       p;
    logic [D_W-1:0]   d;
    logic [5:0]       prev;
    logic             prev_valid;

    logic [5:0]       sample_c;
    logic             legal_c;
    logic [1:0]       idx_c;
    logic [D_W-1:0]   len_c;
    logic             err_c;
    logic [2:0]       code_c;
    logic             stay_c;
    logic             adv_c;
    logic             lock_c;

    // Classify the sample and decide what it means for the tracked cycle
    always_comb begin
        sample_c = {R, Y, G};
        legal_c  = 1'b1;
        idx_c    = 2'd0;
        len_c    = p[0] ? D_W'(YELLOW_LEN) : D_W'(GREEN_LEN);
        err_c    = 1'b0;
        code_c   = 3'd0;
        stay_c   = 1'b0;
        adv_c    = 1'b0;
        lock_c   = 1'b0;

        case (sample_c)
            PAT_P0:  idx_c = 2'd0;
            PAT_P1:  idx_c = 2'd1;
            PAT_P2:  idx_c = 2'd2;
            PAT_P3:  idx_c = 2'd3;
            default: legal_c = 1'b0;
        endcase

        if (!legal_c) begin
            err_c  = 1'b1;
            code_c = CODE_ILLEGAL;
        end else if (state == TRACK) begin
            if (idx_c == p) begin
                if (d < len_c) begin
                    stay_c = 1'b1;
                end else begin
                    err_c  = 1'b1;
                    code_c = CODE_LATE;
                end
            end else if (idx_c == p + 2'd1) begin
                if (d == len_c) begin
                    adv_c = 1'b1;
                end else begin
                    err_c  = 1'b1;
                    code_c = CODE_EARLY;
                end
            end else begin
                err_c  = 1'b1;
                code_c = CODE_ORDER;
            end
        end else begin
            lock_c = prev_valid && (prev == PAT_P3) && (sample_c == PAT_P0);
        end
    end

    // State, tracking registers and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            p          <= 2'd0;
            d          <= '0;
            prev       <= 6'd0;
            prev_valid <= 1'b0;
            locked     <= 1'b0;
            phase      <= '0;
            cycle_done <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= 3'd0;
            err_count  <= '0;
        end else begin
            prev       <= sample_c;
            prev_valid <= 1'b1;
            cycle_done <= 1'b0;
            err_pulse  <= 1'b0;

            if (err_c) begin
                err_pulse <= 1'b1;
                err_code  <= code_c;
                if (clr_err) begin
                    err_count <= ERR_W'(1);
                end else if (err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_W'(1);
                end
                state  <= HUNT;
                locked <= 1'b0;
                phase  <= '0;
            end else begin
                if (clr_err) begin
                    err_count <= '0;
                    err_code  <= 3'd0;
                end
                if (lock_c) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                    p      <= 2'd0;
                    d      <= D_W'(1);
                    phase  <= '0;
                end else if (stay_c) begin
                    d     <= d + D_W'(1);
                    phase <= phase + PH_W'(1);
                end else if (adv_c) begin
                    p <= p + 2'd1;
                    d <= D_W'(1);
                    // Wrapping from B yellow back to A green closes one full cycle
                    if (p == 2'd3) begin
                        phase      <= '0;
                        cycle_done <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ryg_sequence_monitor.sv
// Directed bench for ryg_sequence_monitor: stimulus pushes expected outputs,
// a monitor pops and compares one entry per clock.
module tb_ryg_sequence_monitor;

    logic       clk;
    logic       rst;
    logic [1:0] R;
    logic [1:0] Y;
    logic [1:0] G;
    logic       clr_err;
    logic       locked;
    logic [3:0] phase;
    logic       cycle_done;
    logic       err_pulse;
    logic [2:0] err_code;
    logic [1:0] err_count;

    typedef struct packed {
        logic       locked;
        logic [3:0] phase;
        logic       cd;
        logic       ep;
        logic [2:0] code;
        logic [1:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         total;
    int         bad;
    logic [2:0] exp_code;
    logic [1:0] exp_cnt;

    ryg_sequence_monitor #(
        .GREEN_LEN  (6),
        .YELLOW_LEN (2),
        .PH_W       (4),
        .ERR_W      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .R          (R),
        .Y          (Y),
        .G          (G),
        .clr_err    (clr_err),
        .locked     (locked),
        .phase      (phase),
        .cycle_done (cycle_done),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern index for cycle position k (6 green, 2 yellow per lane)
    function automatic int pat_k(input int k);
        if (k < 6)       return 0;
        else if (k < 8)  return 1;
        else if (k < 14) return 2;
        else             return 3;
    endfunction

    task automatic step(input int pat, input bit c, input bit r,
                        input bit lk, input int ph, input bit cd, input bit ep);
        exp_t e;
        @(negedge clk);
        rst     = r;
        clr_err = c;
        case (pat)
            0:       begin R = 2'b01; Y = 2'b00; G = 2'b10; end
            1:       begin R = 2'b01; Y = 2'b10; G = 2'b00; end
            2:       begin R = 2'b10; Y = 2'b00; G = 2'b01; end
            3:       begin R = 2'b10; Y = 2'b01; G = 2'b00; end
            4:       begin R = 2'b00; Y = 2'b00; G = 2'b11; end
            default: begin R = 2'b00; Y = 2'b00; G = 2'b00; end
        endcase
        e.locked = lk;
        e.phase  = 4'(ph);
        e.cd     = cd;
        e.ep     = ep;
        e.code   = exp_code;
        e.cnt    = exp_cnt;
        q.push_back(e);
    endtask

    task automatic span(input int a, input int b, input bit lk, input bit cd0);
        for (int k = a; k <= b; k++)
            step(pat_k(k), 1'b0, 1'b0, lk, lk ? k : 0, lk && (k == 0) && cd0, 1'b0);
    endtask

    // Monitor: one expected entry per sampled edge
    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #1;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {locked, phase, cycle_done, err_pulse, err_code, err_count};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got lk=%b ph=%0d cd=%b ep=%b code=%0d cnt=%0d required lk=%b ph=%0d cd=%b ep=%b code=%0d cnt=%0d",
                         $time, got.locked, got.phase, got.cd, got.ep, got.code, got.cnt,
                         e.locked, e.phase, e.cd, e.ep, e.code, e.cnt);
            end
        end
    end

    initial begin
        total = 0; bad = 0;
        exp_code = 3'd0; exp_cnt = 2'd0;
        rst = 1'b1; clr_err = 1'b0; R = 2'b00; Y = 2'b00; G = 2'b00;

        // Reset state
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);

        // Start mid-P2, lock at first P0 after P3, three full cycles
        span(10, 15, 0, 0);
        span(0, 15, 1, 0);
        span(0, 15, 1, 1);
        span(0, 15, 1, 1);

        // Short A green -> early
        span(0, 4, 1, 1);
        exp_code = 3'd2; exp_cnt = 2'd1;
        step(1, 0, 0, 0, 0, 0, 1);
        span(6, 15, 0, 0);
        span(0, 15, 1, 0);

        // B yellow held 3 cycles -> late; illegal lamps while hunting
        span(0, 15, 1, 1);
        exp_code = 3'd3; exp_cnt = 2'd2;
        step(3, 0, 0, 0, 0, 0, 1);
        exp_code = 3'd1; exp_cnt = 2'd3;
        step(4, 0, 0, 0, 0, 0, 1);
        step(5, 0, 0, 0, 0, 0, 1);

        // Order errors: P0 -> P2, and P3 -> P1
        span(14, 15, 0, 0);
        span(0, 5, 1, 0);
        exp_code = 3'd4;
        step(2, 0, 0, 0, 0, 0, 1);
        exp_code = 3'd0; exp_cnt = 2'd0;
        step(2, 1, 0, 0, 0, 0, 0);
        span(14, 15, 0, 0);
        span(0, 15, 1, 0);
        exp_code = 3'd4; exp_cnt = 2'd1;
        step(1, 0, 0, 0, 0, 0, 1);

        // Saturation and clr_err interplay
        exp_code = 3'd1; exp_cnt = 2'd2;
        step(5, 0, 0, 0, 0, 0, 1);
        exp_cnt = 2'd3;
        step(4, 0, 0, 0, 0, 0, 1);
        step(5, 0, 0, 0, 0, 0, 1);
        step(4, 0, 0, 0, 0, 0, 1);
        exp_cnt = 2'd1;
        step(4, 1, 0, 0, 0, 0, 1);
        exp_code = 3'd0; exp_cnt = 2'd0;
        step(0, 1, 0, 0, 0, 0, 0);

        // Reset mid-cycle at phase 9, relock only after a fresh P3->P0
        exp_code = 3'd1; exp_cnt = 2'd1;
        step(5, 0, 0, 0, 0, 0, 1);
        span(14, 15, 0, 0);
        span(0, 9, 1, 0);
        exp_code = 3'd0; exp_cnt = 2'd0;
        step(2, 0, 1, 0, 0, 0, 0);
        span(11, 15, 0, 0);
        span(0, 3, 1, 0);
        step(3, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending entries required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
